// File: rtl/fifo_rd_ctrl.sv
// Read-domain pointer/flag controller of the async FIFO: binary read pointer, Gray pointer to write side, empty flag.
// Optional occupancy outputs (rlevel, ralmost_empty) enabled by defining FIFO_RD_LEVEL_EN.
module fifo_rd_ctrl #(
  parameter int unsigned Pointer_Size = 4,
  parameter int unsigned AE_THRESHOLD = 2
) (
  input  logic                    rclk,
  input  logic                    rrst_n,
  input  logic                    rinc,
  input  logic [Pointer_Size-1:0] sync_w2r_ptr,
  output logic [Pointer_Size-1:0] gray_r2w_ptr,
  output logic [Pointer_Size-2:0] raddr,
  output logic                    rempty,
  output logic                    rd_underflow,
  output logic [Pointer_Size-1:0] rlevel,
  output logic                    ralmost_empty
);

  localparam int unsigned PW = Pointer_Size;
  localparam int unsigned AW = Pointer_Size - 1;

  // Reject illegal configurations at elaboration time
  if (PW < 2) begin : g_bad_ptr_size
    $error("fifo_rd_ctrl: Pointer_Size must be >= 2");
  end
  if ((AE_THRESHOLD < 1) || (AE_THRESHOLD > (1 << AW))) begin : g_bad_ae_threshold
    $error("fifo_rd_ctrl: AE_THRESHOLD out of range 1..depth");
  end

  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_rgray;
  logic          r_rempty;
  logic          r_rd_underflow;

  logic          w_rd_en;
  logic [PW-1:0] w_rptr_next;
  logic [PW-1:0] w_rgray_next;

  assign w_rd_en      = rinc & ~r_rempty;
  assign w_rptr_next  = r_rptr + PW'(w_rd_en);
  assign w_rgray_next = w_rptr_next ^ (w_rptr_next >> 1);

  // Binary and Gray pointers advance together so the write side never sees a stale Gray value
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_rptr         <= '0;
      r_rgray        <= '0;
      r_rempty       <= 1'b1;
      r_rd_underflow <= 1'b0;
    end else begin
      r_rptr         <= w_rptr_next;
      r_rgray        <= w_rgray_next;
      r_rempty       <= (w_rgray_next == sync_w2r_ptr);
      r_rd_underflow <= rinc & r_rempty;
    end
  end

  assign gray_r2w_ptr = r_rgray;
  assign raddr        = r_rptr[AW-1:0];
  assign rempty       = r_rempty;
  assign rd_underflow = r_rd_underflow;

`ifdef FIFO_RD_LEVEL_EN
  logic [PW-1:0] w_wbin;
  logic [PW-1:0] w_level_next;
  logic [PW-1:0] r_rlevel;
  logic          r_ralmost_empty;

  // Gray to binary: each bit is the XOR of itself and all higher Gray bits
  always_comb begin
    w_wbin = '0;
    for (int i = 0; i < PW; i++) begin
      w_wbin[i] = ^(sync_w2r_ptr >> i);
    end
  end

  assign w_level_next = w_wbin - w_rptr_next;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_rlevel        <= '0;
      r_ralmost_empty <= 1'b1;
    end else begin
      r_rlevel        <= w_level_next;
      r_ralmost_empty <= (w_level_next <= PW'(AE_THRESHOLD));
    end
  end

  assign rlevel        = r_rlevel;
  assign ralmost_empty = r_ralmost_empty;
`else
  assign rlevel        = '0;
  assign ralmost_empty = 1'b0;
`endif

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
- Read-side pointer/flag controller of the async FIFO; counterpart of the write-side controller in the same FIFO.
- Lives in the read clock domain.
- Owns the binary read pointer and the read address into the dual-port FIFO memory.
- Publishes a registered Gray read pointer to the write domain and produces a registered empty flag from the synchronized Gray write pointer.

Parameters:
- Pointer_Size, 4, pointer width incl. wrap bit; FIFO depth = 2^(Pointer_Size-1); raddr width = Pointer_Size-1.
- AE_THRESHOLD, 2, almost-empty threshold in entries (used only with the optional feature); legal range 1..2^(Pointer_Size-1).

Ports:
- rclk  input  1  read clock.
- rrst_n  input  1  async active-low reset; one clock, reset asynchronous active-low.
- rinc  input  1  read request; pops one entry when accepted.
- sync_w2r_ptr  input  Pointer_Size  Gray write pointer, already 2-FF synchronized into rclk.
- gray_r2w_ptr  output  Pointer_Size  registered Gray read pointer, sent to the write-domain synchronizer.
- raddr  output  Pointer_Size-1  memory read address = rptr[Pointer_Size-2:0].
- rempty  output  1  registered empty flag.
- rd_underflow  output  1  one-cycle registered pulse: rinc seen while rempty=1.
- rlevel  output  Pointer_Size  occupancy seen from read side (optional feature).
- ralmost_empty  output  1  registered, rlevel_next <= AE_THRESHOLD (optional feature).

Behaviour:
- Internal state: rptr binary [Pointer_Size-1:0].
- Reset (async, rrst_n=0): rptr=0, gray_r2w_ptr=0, rempty=1, rd_underflow=0, rlevel=0, ralmost_empty=1.
- Accept: rd_en = rinc & ~rempty.
- Next-state values:
  - rptr_next = rptr + rd_en, modulo 2^Pointer_Size; natural wrap 2^P-1 -> 0.
  - rgray_next = rptr_next ^ (rptr_next >> 1). Generic XOR form, not a lookup table; must work for any Pointer_Size >= 2.
- Each rclk:
  - rptr <= rptr_next
  - gray_r2w_ptr <= rgray_next
  - rempty <= (rgray_next == sync_w2r_ptr)
- gray_r2w_ptr and rptr always update in the same cycle; no one-cycle Gray lag.
- raddr is combinational from rptr. The memory read is addressed by the current raddr, and data is consumed in the cycle rd_en=1.
- Empty: full Gray equality, including the MSB wrap bit.
- Read past empty: ignored. rptr is unchanged and rd_underflow <= 1 for exactly one cycle. rd_underflow <= 0 in every other cycle.
- rinc with FIFO holding exactly 1 entry: the pop is accepted and rempty rises on the next edge. No back-to-back over-read is possible.
- Write pointer change while rinc=1: flags use the sync_w2r_ptr value present at the edge. rempty is pessimistic (may stay 1 for up to sync latency) but never falsely 0.
- sync_w2r_ptr changes by at most one Gray step per rclk; no multi-bit-change handling is required.
- Reset mid-operation: all state returns to reset values immediately; no partial pop.

Optional Feature:
- Macro: FIFO_RD_LEVEL_EN.
- Defined:
  - wbin = Gray-to-binary(sync_w2r_ptr), prefix-XOR from MSB.
  - rlevel <= wbin - rptr_next, mod 2^Pointer_Size; range 0..2^(Pointer_Size-1).
  - ralmost_empty <= (wbin - rptr_next) <= AE_THRESHOLD.
  - Both are registered, same-cycle with rempty.
- Undefined: rlevel tied to 0, ralmost_empty tied to 0; no Gray-to-binary or subtractor logic is synthesized. Port list is identical in both builds.

Test Plan:
- Reset: hold rrst_n=0 with sync_w2r_ptr=4'b0011 -> rempty=1, gray_r2w_ptr=0, raddr=0, rd_underflow=0. After release, next edge -> rempty=0.
- Drain: sync_w2r_ptr=Gray(3)=4'b0010, rinc=1 for 4 cycles -> three pops with raddr 0,1,2. gray_r2w_ptr 0001,0011,0010. rempty=1 after the 3rd edge; 4th cycle rd_underflow=1, rptr stays 3.
- Wrap: write pointer walks 0..15 then 0 while reading continuously -> raddr sequence 0..7,0..7. gray_r2w_ptr passes 1000 -> 0000, single-bit change each step. rempty asserts only on equality, including MSB.
- Full FIFO drain: sync_w2r_ptr=Gray(8)=4'b1100, rptr=0 -> 8 accepted pops, rempty=1 after the 8th, gray_r2w_ptr=4'b1100.
- Mid-op reset: after 5 pops, pulse rrst_n low asynchronously between edges -> rptr, gray_r2w_ptr, raddr=0 and rempty=1 immediately, without waiting for rclk.
- FIFO_RD_LEVEL_EN, AE_THRESHOLD=2: write pointer=6, rptr=0 -> rlevel=6, ralmost_empty=0. Pop 4 times -> rlevel 5,4,3,2, with ralmost_empty=1 at level 2. Macro undefined -> both outputs constant 0.
